// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm: RC4 key-scheduling swap pass over an S-memory with two-cycle read latency.
module ksa_swap_fsm #(
  parameter int KEY_LEN = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_LEN-1:0]   secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   done
);
  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] READ_I  = 4'd1;
  localparam logic [3:0] WAIT_I  = 4'd2;
  localparam logic [3:0] CAPT_I  = 4'd3;
  localparam logic [3:0] READ_J  = 4'd4;
  localparam logic [3:0] WAIT_J  = 4'd5;
  localparam logic [3:0] CAPT_J  = 4'd6;
  localparam logic [3:0] WRITE_I = 4'd7;
  localparam logic [3:0] WRITE_J = 4'd8;
  localparam logic [3:0] NEXT    = 4'd9;
  localparam logic [3:0] DONE    = 4'd10;
  localparam int KW = KEY_LEN > 1 ? $clog2(KEY_LEN) : 1;
  logic [3:0]    state;
  logic [7:0]    i, j, si, sj;
  logic [KW-1:0] kidx;
  logic [7:0]    key_b [2**KW];
  // key byte 0 is the most-significant byte; unused slots padded so kidx indexes a power-of-two table
  for (genvar g = 0; g < 2**KW; g++) begin : g_key
    if (g < KEY_LEN) begin : g_v
      assign key_b[g] = secret_key[8*(KEY_LEN-1-g) +: 8];
    end else begin : g_z
      assign key_b[g] = 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= READ_I;
          i     <= '0;
          j     <= '0;
          kidx  <= '0;
        end
        READ_I:  state <= WAIT_I;
        WAIT_I:  state <= CAPT_I;
        CAPT_I: begin
          si    <= s_q;
          j     <= j + s_q + key_b[kidx];
          state <= READ_J;
        end
        READ_J:  state <= WAIT_J;
        WAIT_J:  state <= CAPT_J;
        CAPT_J: begin
          sj    <= s_q;
          state <= WRITE_I;
        end
        WRITE_I: state <= WRITE_J;
        WRITE_J: state <= NEXT;
        NEXT: if (i == 8'hff) state <= DONE;
        else begin
          i     <= i + 8'd1;
          kidx  <= (kidx == KW'(KEY_LEN-1)) ? '0 : kidx + 1'b1;
          state <= READ_I;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_comb begin
    s_wren    = state == WRITE_I || state == WRITE_J;
    done      = state == DONE;
    s_address = (state == READ_I || state == WAIT_I || state == CAPT_I || state == WRITE_I) ? i :
                (state == READ_J || state == WAIT_J || state == CAPT_J || state == WRITE_J) ? j : 8'd0;
    s_data    = state == WRITE_I ? sj : state == WRITE_J ? si : 8'd0;
  end
endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb_ksa_swap_fsm: directed bench with a latency-2 S-memory model and an RC4 KSA reference.
module tb_ksa_swap_fsm;
  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [23:0] secret_key;
  logic [7:0]  s_q, s_address, s_data;
  logic        s_wren, done;
  int          cyc = 0, checks = 0, errs = 0, wcount = 0, run = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  mem [256];
  logic [7:0]  ref_s [256];
  logic [7:0]  a1;
  logic [7:0]  hist [4];

  typedef struct {
    logic       care;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wren;
  } vec_t;
  typedef struct {
    logic [23:0] key;
    int          hold;
    logic        iter;
  } scen_t;
  vec_t  iv [27];
  scen_t sc [3];

  ksa_swap_fsm dut (
    .clk(clk), .reset_n(reset_n), .start(start), .secret_key(secret_key),
    .s_q(s_q), .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (s_wren) mem[s_address] <= s_data;
    a1  <= s_address;
    s_q <= mem[a1];
  end

  // bus monitor: writes come in pairs; first targets the CAPT_I address, second the CAPT_J address
  always @(negedge clk) begin
    if (s_wren) begin
      wcount++;
      run++;
      if (mon_en) begin
        checks++;
        if (run > 2 || s_address != (run == 1 ? hist[3] : hist[1])) begin
          errs++;
          $display("FAIL bus_wr_addr: addr %0d run %0d", s_address, run);
        end
      end
    end else begin
      if (mon_en && run != 0) begin
        checks++;
        if (run != 2) begin
          errs++;
          $display("FAIL bus_pair: run length %0d expected 2", run);
        end
      end
      run = 0;
    end
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = s_address;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(input logic [23:0] key);
    logic [7:0] jj, t;
    logic [23:0] k;
    k = key;
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + ref_s[n] + k[8*(2-(n%3)) +: 8];
      t = ref_s[n];
      ref_s[n] = ref_s[jj];
      ref_s[jj] = t;
    end
  endtask

  task automatic init_mem();
    for (int n = 0; n < 256; n++) mem[n] = 8'(n);
  endtask

  task automatic run_scen(input int id, input logic [23:0] key, input int hold, input logic iter);
    int c0, first_done, ndone, bad;
    init_mem();
    model(key);
    first_done = -1;
    ndone = 0;
    @(negedge clk);
    wcount = 0;
    secret_key = key;
    start = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 2315; k++) begin
      @(negedge clk);
      if (k + 1 >= hold) start = 1'b0;
      if (iter && k < 27) begin
        chk($sformatf("s%0d_it_wren_%0d", id, k), s_wren, iv[k].wren);
        if (iv[k].care) chk($sformatf("s%0d_it_addr_%0d", id, k), s_address, iv[k].addr);
        if (iv[k].wren) chk($sformatf("s%0d_it_data_%0d", id, k), s_data, iv[k].data);
      end
      if (iter && k == 27) chk($sformatf("s%0d_s2s3", id), {mem[2], mem[3]}, {8'd3, 8'd2});
      if (done) begin
        if (first_done < 0) first_done = cyc - c0;
        ndone++;
      end
    end
    chk($sformatf("s%0d_done_cycle", id), first_done, 2305);
    chk($sformatf("s%0d_done_count", id), ndone, 1);
    chk($sformatf("s%0d_writes", id), wcount, 512);
    bad = 0;
    for (int n = 0; n < 256; n++) if (mem[n] != ref_s[n]) bad++;
    chk($sformatf("s%0d_final_s_bad_bytes", id), bad, 0);
  endtask

  initial begin
    logic [7:0] jt [3];
    int ph, it, w;
    jt = '{8'd0, 8'd1, 8'd3};
    for (int k = 0; k < 27; k++) begin
      it = k / 9;
      ph = k % 9;
      iv[k].care = ph != 8;
      iv[k].addr = (ph < 3 || ph == 6) ? 8'(it) : jt[it];
      iv[k].wren = ph == 6 || ph == 7;
      iv[k].data = ph == 6 ? jt[it] : 8'(it);
    end
    sc[0] = '{24'h000000, 1, 1'b1};
    sc[1] = '{24'h000249, 1, 1'b0};
    sc[2] = '{24'h000249, 50, 1'b0};
    reset_n = 1'b0;
    start = 1'b0;
    secret_key = '0;
    init_mem();
    repeat (3) @(negedge clk);
    chk("rst_wren", s_wren, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", s_address, 0);
    chk("rst_data", s_data, 0);
    reset_n = 1'b1;
    @(negedge clk);
    run = 0;
    mon_en = 1'b1;
    for (int s = 0; s < 3; s++) run_scen(s + 1, sc[s].key, sc[s].hold, sc[s].iter);
    mon_en = 1'b0;
    init_mem();
    @(negedge clk);
    secret_key = 24'h000249;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!s_wren && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("s4_reach_write_i", int'(s_wren), 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("s4_abort_wren", s_wren, 0);
    chk("s4_abort_done", done, 0);
    chk("s4_abort_addr", s_address, 0);
    wcount = 0;
    w = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) w++;
    end
    chk("s4_no_writes_after_abort", wcount, 0);
    chk("s4_no_done_after_abort", w, 0);
    run = 0;
    mon_en = 1'b1;
    run_scen(5, 24'h000249, 1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
